preg_release_queue: RTL and testbench

Commit-side release queue that drives the physical-register free list's free port. Each cycle the ROB retires up to COMMIT_W instructions; for every retired instruction that wrote a destination, the stale physical register (the mapping it displaced at rename) is pushed here. The block drains one register per cycle into the free list's single free_req/free_preg port, absorbing commit bursts and holding off during checkpoint recovery.

---
 rtl/preg_release_queue.sv | 152 +++++++++++++++
 tb/tb_preg_release_queue.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/preg_release_queue.sv
// preg_release_queue
//   Commit-side release queue feeding the physical-register free list. Each
//   cycle up to COMMIT_W retiring instructions may push their stale physical
//   register; the queue drains one register per cycle into the free list's
//   single free port, and holds off while the free list restores a checkpoint.
//
// Optional feature (macro PREG_RELEASE_BYPASS_EN):
//   When defined, an empty queue with recover_i low forwards the lowest
//   eligible commit slot straight to free_req_o/free_preg_o in the same cycle
//   and does not enqueue it. This is a combinational commit-to-free path.
//   When undefined, the minimum commit-to-free latency is one cycle.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   commit_valid_i       per-slot retire valid (slot 0 oldest)
//   commit_has_rd_i      per-slot "wrote a destination"
//   commit_old_preg_i    per-slot stale physical register
//   commit_ready_o       room for a full COMMIT_W-wide retire (registered count)
//   recover_i            free list restoring a checkpoint; freezes popping
//   free_req_o           release strobe to the free list
//   free_preg_o          register being released (0 when empty)
//   count_o              current occupancy
//   overflow_err_o       sticky: an eligible push was dropped
module preg_release_queue #(
   parameter int unsigned N_PHYS_REGS = 64,
   parameter int unsigned PREG_W      = $clog2(N_PHYS_REGS),
   parameter int unsigned COMMIT_W    = 2,
   parameter int unsigned Q_DEPTH     = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [COMMIT_W-1:0]              commit_valid_i,
   input  logic [COMMIT_W-1:0]              commit_has_rd_i,
   input  logic [COMMIT_W-1:0][PREG_W-1:0]  commit_old_preg_i,
   output logic                             commit_ready_o,
   input  logic                             recover_i,
   output logic                             free_req_o,
   output logic [PREG_W-1:0]                free_preg_o,
   output logic [$clog2(Q_DEPTH):0]         count_o,
   output logic                             overflow_err_o
);

   localparam int unsigned PTR_W = $clog2(Q_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PREG_W-1:0]   mem [Q_DEPTH];
   logic [PTR_W-1:0]    head;
   logic [PTR_W-1:0]    tail;
   logic [CNT_W-1:0]    count;
   logic                overflow;

   logic [COMMIT_W-1:0] eligible;
   logic [COMMIT_W-1:0] push_mask;
   logic [COMMIT_W-1:0] wr_en;
   logic [PTR_W-1:0]    wr_idx [COMMIT_W];
   logic [CNT_W-1:0]    space;
   logic [CNT_W-1:0]    n_push;
   logic                empty;
   logic                pop;
   logic                drop;
   logic                bypass;
   logic [PREG_W-1:0]   bypass_preg;

   assign empty = (count == '0);
   // Space comes from registered occupancy only, so a same-cycle pop never
   // makes room for a push.
   assign space = CNT_W'(Q_DEPTH) - count;

   always_comb begin
      eligible = '0;
      for (int unsigned k = 0; k < COMMIT_W; k++) begin
         eligible[k] = commit_valid_i[k] && commit_has_rd_i[k] &&
                       (commit_old_preg_i[k] != '0);
      end
   end

`ifdef PREG_RELEASE_BYPASS_EN
   always_comb begin
      bypass      = 1'b0;
      bypass_preg = '0;
      push_mask   = eligible;
      if (empty && !recover_i) begin
         for (int unsigned k = 0; k < COMMIT_W; k++) begin
            if (!bypass && eligible[k]) begin
               bypass       = 1'b1;
               bypass_preg  = commit_old_preg_i[k];
               push_mask[k] = 1'b0;
            end
         end
      end
   end
`else
   assign bypass      = 1'b0;
   assign bypass_preg = '0;
   assign push_mask   = eligible;
`endif

   // Compact eligible slots into consecutive tail positions, oldest first;
   // slots beyond the free space are dropped and flagged.
   always_comb begin
      n_push = '0;
      drop   = 1'b0;
      wr_en  = '0;
      for (int unsigned k = 0; k < COMMIT_W; k++) begin
         wr_idx[k] = '0;
      end
      for (int unsigned k = 0; k < COMMIT_W; k++) begin
         if (push_mask[k]) begin
            if (n_push < space) begin
               wr_en[k]  = 1'b1;
               wr_idx[k] = tail + n_push[PTR_W-1:0];
               n_push    = n_push + CNT_W'(1);
            end else begin
               drop = 1'b1;
            end
         end
      end
   end

   assign pop = !empty && !recover_i;

   assign free_req_o     = pop || bypass;
   assign free_preg_o    = bypass ? bypass_preg : (empty ? '0 : mem[head]);
   assign commit_ready_o = (space >= CNT_W'(COMMIT_W));
   assign count_o        = count;
   assign overflow_err_o = overflow;

   always_ff @(posedge clk) begin
      if (rst) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         head  <= head + PTR_W'(pop);
         tail  <= tail + n_push[PTR_W-1:0];
         count <= count + n_push - CNT_W'(pop);
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < COMMIT_W; k++) begin
         if (wr_en[k]) begin
            mem[wr_idx[k]] <= commit_old_preg_i[k];
         end
      end
   end

endmodule

// File: tb/tb_preg_release_queue.sv
// tb_preg_release_queue
//   Self-checking bench for preg_release_queue (COMMIT_W=2, Q_DEPTH=8,
//   PREG_W=6). A reference model holds the queue contents as a plain list and
//   predicts every output from the commit/pop/drop rules; directed scenarios
//   add fixed expected values. Honors PREG_RELEASE_BYPASS_EN when defined.
module tb_preg_release_queue;

   localparam int unsigned PREG_W   = 6;
   localparam int unsigned COMMIT_W = 2;
   localparam int unsigned Q_DEPTH  = 8;
   localparam int unsigned CNT_W    = 4;

   logic                            clk = 1'b0;
   logic                            rst;
   logic [COMMIT_W-1:0]             commit_valid_i;
   logic [COMMIT_W-1:0]             commit_has_rd_i;
   logic [COMMIT_W-1:0][PREG_W-1:0] commit_old_preg_i;
   logic                            commit_ready_o;
   logic                            recover_i;
   logic                            free_req_o;
   logic [PREG_W-1:0]               free_preg_o;
   logic [CNT_W-1:0]                count_o;
   logic                            overflow_err_o;

   always #5 clk = ~clk;

   preg_release_queue #(
      .N_PHYS_REGS (64),
      .PREG_W      (PREG_W),
      .COMMIT_W    (COMMIT_W),
      .Q_DEPTH     (Q_DEPTH)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .commit_valid_i    (commit_valid_i),
      .commit_has_rd_i   (commit_has_rd_i),
      .commit_old_preg_i (commit_old_preg_i),
      .commit_ready_o    (commit_ready_o),
      .recover_i         (recover_i),
      .free_req_o        (free_req_o),
      .free_preg_o       (free_preg_o),
      .count_o           (count_o),
      .overflow_err_o    (overflow_err_o)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [PREG_W-1:0] q[$];
   logic [PREG_W-1:0] exp_freed[$];
   logic [PREG_W-1:0] freed[$];
   bit                ovf_m;

   // Observed / expected per cycle: {req, preg, count, ready, ovf}
   logic              obs_req, obs_ready, obs_ovf;
   logic [PREG_W-1:0] obs_preg;
   logic [CNT_W-1:0]  obs_cnt;
   logic              exp_req, exp_ready, exp_ovf;
   logic [PREG_W-1:0] exp_preg;
   logic [CNT_W-1:0]  exp_cnt;
   logic [12:0]       obs_vec, exp_vec;

   task automatic model_clear();
      q.delete();
      exp_freed.delete();
      freed.delete();
      ovf_m = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      commit_valid_i = '0;
      commit_has_rd_i = '0;
      commit_old_preg_i = '0;
      recover_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   // One clock: drive inputs, sample outputs, predict from the model, then
   // advance the model by the clock edge. Starts and ends just after negedge.
   task automatic cycle(input logic [1:0] v, input logic [1:0] h,
                        input logic [PREG_W-1:0] p0, input logic [PREG_W-1:0] p1,
                        input logic rec);
      logic [PREG_W-1:0] p [2];
      logic [1:0] elig;
      bit byp;
      int bslot;
      int sz;
      int pushed;
      p[0] = p0;
      p[1] = p1;
      for (int k = 0; k < 2; k++) elig[k] = v[k] && h[k] && (p[k] != '0);
      commit_valid_i       = v;
      commit_has_rd_i      = h;
      commit_old_preg_i[0] = p0;
      commit_old_preg_i[1] = p1;
      recover_i            = rec;
      #1;
      byp = 1'b0;
      bslot = 0;
`ifdef PREG_RELEASE_BYPASS_EN
      if (q.size() == 0 && !rec) begin
         for (int k = 0; k < 2; k++) begin
            if (!byp && elig[k]) begin
               byp = 1'b1;
               bslot = k;
            end
         end
      end
`endif
      exp_cnt   = CNT_W'(q.size());
      exp_ready = (int'(Q_DEPTH) - q.size()) >= int'(COMMIT_W);
      exp_ovf   = ovf_m;
      if (byp) begin
         exp_req  = 1'b1;
         exp_preg = p[bslot];
      end else begin
         exp_req  = (q.size() > 0) && !rec;
         exp_preg = (q.size() > 0) ? q[0] : '0;
      end
      obs_req   = free_req_o;
      obs_preg  = free_preg_o;
      obs_cnt   = count_o;
      obs_ready = commit_ready_o;
      obs_ovf   = overflow_err_o;
      obs_vec   = {obs_req, obs_preg, obs_cnt, obs_ready, obs_ovf};
      exp_vec   = {exp_req, exp_preg, exp_cnt, exp_ready, exp_ovf};
      if (obs_req === 1'b1) freed.push_back(obs_preg);
      @(posedge clk);
      sz = q.size();
      pushed = 0;
      if (byp) exp_freed.push_back(p[bslot]);
      else if (sz > 0 && !rec) exp_freed.push_back(q.pop_front());
      for (int k = 0; k < 2; k++) begin
         if (elig[k] && !(byp && bslot == k)) begin
            if (pushed < int'(Q_DEPTH) - sz) begin
               q.push_back(p[k]);
               pushed++;
            end else begin
               ovf_m = 1'b1;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_o); end
      checks++; if (free_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", free_req_o); end
      checks++; if (free_preg_o !== 6'd0) begin errors++; $display("FAIL reset_preg got %0d want 0", free_preg_o); end
      checks++; if (commit_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", commit_ready_o); end
      checks++; if (overflow_err_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", overflow_err_o); end
   endtask

   task automatic test_single();
      cycle(2'b01, 2'b01, 6'd40, 6'd0, 1'b0);
      checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL single_c0 got %h want %h", obs_vec, exp_vec); end
`ifdef PREG_RELEASE_BYPASS_EN
      checks++; if (obs_req !== 1'b1 || obs_preg !== 6'd40) begin errors++; $display("FAIL single_bypass got req=%0b preg=%0d want 1/40", obs_req, obs_preg); end
`endif
      cycle(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
      checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL single_c1 got %h want %h", obs_vec, exp_vec); end
`ifndef PREG_RELEASE_BYPASS_EN
      checks++; if (obs_req !== 1'b1 || obs_preg !== 6'd40) begin errors++; $display("FAIL single_free got req=%0b preg=%0d want 1/40", obs_req, obs_preg); end
`endif
      cycle(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
      checks++; if (obs_cnt !== 4'd0 || obs_req !== 1'b0) begin errors++; $display("FAIL single_empty got cnt=%0d req=%0b want 0/0", obs_cnt, obs_req); end
   endtask

   task automatic test_zero_preg();
      logic [PREG_W-1:0] want [3];
      bit bad;
      want[0] = 6'd33; want[1] = 6'd50; want[2] = 6'd51;
      freed.delete();
      cycle(2'b11, 2'b11, 6'd33, 6'd0, 1'b0);
      checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL zero_c0 got %h want %h", obs_vec, exp_vec); end
      cycle(2'b11, 2'b11, 6'd50, 6'd51, 1'b0);
      checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL zero_c1 got %h want %h", obs_vec, exp_vec); end
      for (int i = 0; i < 4; i++) begin
         cycle(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
         checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL zero_drain%0d got %h want %h", i, obs_vec, exp_vec); end
      end
      bad = (freed.size() != 3);
      for (int i = 0; i < 3 && !bad; i++) if (freed[i] !== want[i]) bad = 1'b1;
      checks++; if (bad) begin errors++; $display("FAIL zero_order got %0d frees (first %0d) want 33,50,51", freed.size(), freed.size() > 0 ? freed[0] : 6'd0); end
   endtask

   task automatic test_overflow();
      logic [PREG_W-1:0] a, b;
      bit bad;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         a = 6'(2*i + 1);
         b = 6'(2*i + 2);
         cycle(2'b11, 2'b11, a, b, 1'b0);
         checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL ovf_c%0d got %h want %h", i, obs_vec, exp_vec); end
`ifndef PREG_RELEASE_BYPASS_EN
         if (i == 6) begin
            checks++; if (obs_cnt !== 4'd7 || obs_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready7 got cnt=%0d rdy=%0b want 7/0", obs_cnt, obs_ready); end
         end
`endif
      end
      for (int i = 0; i < 10; i++) begin
         cycle(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
         checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL ovf_drain%0d got %h want %h", i, obs_vec, exp_vec); end
      end
      checks++; if (obs_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", obs_ovf); end
      bad = (freed.size() != exp_freed.size());
      for (int i = 0; i < freed.size() && !bad; i++) if (freed[i] !== exp_freed[i]) bad = 1'b1;
      checks++; if (bad) begin errors++; $display("FAIL ovf_order got %0d frees want %0d in model order", freed.size(), exp_freed.size()); end
`ifndef PREG_RELEASE_BYPASS_EN
      bad = (freed.size() != 14);
      for (int i = 0; i < 13 && !bad; i++) if (freed[i] !== 6'(i + 1)) bad = 1'b1;
      if (!bad && freed[13] !== 6'd15) bad = 1'b1;
      checks++; if (bad) begin errors++; $display("FAIL ovf_accepted got %0d frees want 1..13,15", freed.size()); end
`endif
   endtask

   task automatic test_reset_mid();
      cycle(2'b11, 2'b11, 6'd21, 6'd22, 1'b1);
      cycle(2'b11, 2'b11, 6'd23, 6'd24, 1'b1);
      cycle(2'b11, 2'b01, 6'd25, 6'd26, 1'b1);
      cycle(2'b00, 2'b00, 6'd0, 6'd0, 1'b1);
      checks++; if (obs_cnt !== 4'd5 || obs_ovf !== 1'b1) begin errors++; $display("FAIL rstmid_pre got cnt=%0d ovf=%0b want 5/1", obs_cnt, obs_ovf); end
      rst = 1'b1;
      commit_valid_i = '0;
      recover_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", count_o); end
      checks++; if (free_req_o !== 1'b0) begin errors++; $display("FAIL rstmid_req got %0b want 0", free_req_o); end
      checks++; if (commit_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %0b want 1", commit_ready_o); end
      checks++; if (overflow_err_o !== 1'b0) begin errors++; $display("FAIL rstmid_ovf got %0b want 0", overflow_err_o); end
      rst = 1'b0;
      model_clear();
   endtask

   task automatic test_recover();
      do_reset();
      cycle(2'b11, 2'b11, 6'd35, 6'd36, 1'b1);
      checks++; if (obs_req !== 1'b0) begin errors++; $display("FAIL rec_c0 got req=%0b want 0", obs_req); end
      cycle(2'b01, 2'b01, 6'd37, 6'd0, 1'b1);
      checks++; if (obs_req !== 1'b0 || obs_vec !== exp_vec) begin errors++; $display("FAIL rec_c1 got %h want %h", obs_vec, exp_vec); end
      cycle(2'b00, 2'b00, 6'd0, 6'd0, 1'b1);
      checks++; if (obs_req !== 1'b0 || obs_cnt !== 4'd3) begin errors++; $display("FAIL rec_c2 got req=%0b cnt=%0d want 0/3", obs_req, obs_cnt); end
      for (int i = 0; i < 3; i++) begin
         cycle(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
         checks++; if (obs_req !== 1'b1 || obs_preg !== 6'(35 + i)) begin errors++; $display("FAIL rec_drain%0d got req=%0b preg=%0d want 1/%0d", i, obs_req, obs_preg, 35 + i); end
      end
      cycle(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
      checks++; if (obs_vec !== exp_vec || obs_req !== 1'b0) begin errors++; $display("FAIL rec_empty got %h want %h", obs_vec, exp_vec); end
   endtask

   task automatic test_wrap();
      logic [PREG_W-1:0] pushed_vals[$];
      logic [PREG_W-1:0] a, b;
      bit bad;
      do_reset();
      for (int i = 0; i < 3; i++) cycle(2'b11, 2'b11, 6'(i + 1), 6'(i + 10), 1'b1);
      for (int i = 0; i < 6; i++) cycle(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
      freed.delete();
      for (int i = 0; i < 3; i++) begin
         a = 6'($urandom_range(1, 63));
         b = 6'($urandom_range(1, 63));
         pushed_vals.push_back(a);
         pushed_vals.push_back(b);
         cycle(2'b11, 2'b11, a, b, 1'b1);
      end
      for (int i = 0; i < 7; i++) begin
         cycle(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
         checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL wrap_drain%0d got %h want %h", i, obs_vec, exp_vec); end
      end
      bad = (freed.size() != 6);
      for (int i = 0; i < 6 && !bad; i++) if (freed[i] !== pushed_vals[i]) bad = 1'b1;
      checks++; if (bad) begin errors++; $display("FAIL wrap_order got %0d frees want 6 in push order", freed.size()); end
      checks++; if (obs_cnt !== 4'd0 || obs_preg !== 6'd0 || obs_req !== 1'b0) begin errors++; $display("FAIL wrap_empty got cnt=%0d preg=%0d req=%0b want 0/0/0", obs_cnt, obs_preg, obs_req); end
   endtask

   task automatic test_random();
      logic [1:0] v, h;
      logic [PREG_W-1:0] a, b;
      logic rec;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         v = ((i % 40) < 25) ? 2'($urandom) : 2'b00;
         h = 2'($urandom);
         a = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
         b = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
         rec = ($urandom_range(0, 4) == 0);
         cycle(v, h, a, b, rec);
         checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL rand_c%0d got %h want %h", i, obs_vec, exp_vec); end
      end
   endtask

   initial begin
      rst = 1'b1;
      commit_valid_i = '0;
      commit_has_rd_i = '0;
      commit_old_preg_i = '0;
      recover_i = 1'b0;
      test_reset();
      test_single();
      test_zero_preg();
      test_overflow();
      test_reset_mid();
      test_recover();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
